// File: rtl/ex_mem_branch_stage.sv
// EX/MEM pipeline register with branch resolution, mispredict flush/redirect,
// predictor training port and saturating branch/mispredict counters.
module ex_mem_branch_stage #(
    parameter int unsigned COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic [63:0]        PC_in,
    input  logic [63:0]        immData_in,
    input  logic [63:0]        alu_result_in,
    input  logic [63:0]        data2_in,
    input  logic               zero_in,
    input  logic [3:0]         Funct_in,
    input  logic [4:0]         rd_in,
    input  logic               Branch_in,
    input  logic               prediction_in,
    input  logic               MemRead_in,
    input  logic               MemtoReg_in,
    input  logic               MemWrite_in,
    input  logic               RegWrite_in,
    output logic [63:0]        alu_result_out,
    output logic [63:0]        data2_out,
    output logic [4:0]         rd_out,
    output logic               MemRead_out,
    output logic               MemtoReg_out,
    output logic               MemWrite_out,
    output logic               RegWrite_out,
    output logic               flush,
    output logic [63:0]        redirect_PC,
    output logic               update_valid,
    output logic [63:0]        update_PC,
    output logic               update_taken,
    output logic [COUNT_W-1:0] branch_count,
    output logic [COUNT_W-1:0] mispredict_count
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

    state_t             state_q, state_d;
    logic [63:0]        alu_result_q, alu_result_d;
    logic [63:0]        data2_q, data2_d;
    logic [4:0]         rd_q, rd_d;
    logic               mem_read_q, mem_read_d;
    logic               mem_to_reg_q, mem_to_reg_d;
    logic               mem_write_q, mem_write_d;
    logic               reg_write_q, reg_write_d;
    logic               flush_q, flush_d;
    logic [63:0]        redirect_q, redirect_d;
    logic               update_valid_q, update_valid_d;
    logic [63:0]        update_pc_q, update_pc_d;
    logic               update_taken_q, update_taken_d;
    logic [COUNT_W-1:0] branch_count_q, branch_count_d;
    logic [COUNT_W-1:0] mispredict_count_q, mispredict_count_d;

    logic               taken;
    logic               resolving;
    logic               mispredict;
    logic [63:0]        target_pc;
    logic [63:0]        fall_pc;

    // Bit 3 of the function code does not affect the branch condition.
    always_comb begin
        taken = 1'b0;
        casez (Funct_in)
            4'b?000: taken = zero_in;
            4'b?001: taken = !zero_in;
            4'b?100: taken = alu_result_in[63];
            4'b?101: taken = !alu_result_in[63];
            default: taken = 1'b0;
        endcase
    end

    assign target_pc  = PC_in + (immData_in << 1);
    assign fall_pc    = PC_in + 64'd4;
    assign resolving  = (state_q == RUN) && !stall && Branch_in;
    assign mispredict = resolving && (taken != prediction_in);

    always_comb begin
        state_d            = state_q;
        alu_result_d       = alu_result_q;
        data2_d            = data2_q;
        rd_d               = rd_q;
        mem_read_d         = mem_read_q;
        mem_to_reg_d       = mem_to_reg_q;
        mem_write_d        = mem_write_q;
        reg_write_d        = reg_write_q;
        flush_d            = 1'b0;
        redirect_d         = redirect_q;
        update_valid_d     = 1'b0;
        update_pc_d        = update_pc_q;
        update_taken_d     = update_taken_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;

        case (state_q)
            RUN: begin
                if (!stall) begin
                    alu_result_d = alu_result_in;
                    data2_d      = data2_in;
                    rd_d         = rd_in;
                    mem_read_d   = MemRead_in;
                    mem_to_reg_d = MemtoReg_in;
                    mem_write_d  = MemWrite_in;
                    reg_write_d  = RegWrite_in;
                end
                if (resolving) begin
                    update_valid_d = 1'b1;
                    update_pc_d    = PC_in;
                    update_taken_d = taken;
                    if (branch_count_q != '1) begin
                        branch_count_d = branch_count_q + CNT_ONE;
                    end
                end
                if (mispredict) begin
                    flush_d    = 1'b1;
                    redirect_d = taken ? target_pc : fall_pc;
                    state_d    = FLUSH;
                    if (mispredict_count_q != '1) begin
                        mispredict_count_d = mispredict_count_q + CNT_ONE;
                    end
                end
            end
            FLUSH: begin
                // Wrong-path instruction: squash side effects, ignore stall and Branch_in.
                alu_result_d = alu_result_in;
                data2_d      = data2_in;
                rd_d         = '0;
                mem_read_d   = 1'b0;
                mem_to_reg_d = 1'b0;
                mem_write_d  = 1'b0;
                reg_write_d  = 1'b0;
                state_d      = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q            <= RUN;
            alu_result_q       <= '0;
            data2_q            <= '0;
            rd_q               <= '0;
            mem_read_q         <= 1'b0;
            mem_to_reg_q       <= 1'b0;
            mem_write_q        <= 1'b0;
            reg_write_q        <= 1'b0;
            flush_q            <= 1'b0;
            redirect_q         <= '0;
            update_valid_q     <= 1'b0;
            update_pc_q        <= '0;
            update_taken_q     <= 1'b0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            state_q            <= state_d;
            alu_result_q       <= alu_result_d;
            data2_q            <= data2_d;
            rd_q               <= rd_d;
            mem_read_q         <= mem_read_d;
            mem_to_reg_q       <= mem_to_reg_d;
            mem_write_q        <= mem_write_d;
            reg_write_q        <= reg_write_d;
            flush_q            <= flush_d;
            redirect_q         <= redirect_d;
            update_valid_q     <= update_valid_d;
            update_pc_q        <= update_pc_d;
            update_taken_q     <= update_taken_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign alu_result_out   = alu_result_q;
    assign data2_out        = data2_q;
    assign rd_out           = rd_q;
    assign MemRead_out      = mem_read_q;
    assign MemtoReg_out     = mem_to_reg_q;
    assign MemWrite_out     = mem_write_q;
    assign RegWrite_out     = reg_write_q;
    assign flush            = flush_q;
    assign redirect_PC      = redirect_q;
    assign update_valid     = update_valid_q;
    assign update_PC        = update_pc_q;
    assign update_taken     = update_taken_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_ex_mem_branch_stage.sv
// Bench for ex_mem_branch_stage (COUNT_W=4): directed vector table, hand-written
// stall/reset/saturation sequences, then random stimulus against a reference model.
module tb_ex_mem_branch_stage;

    localparam int unsigned CW   = 4;
    localparam int unsigned CMAX = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall;
    logic [63:0]   PC_in, immData_in, alu_result_in, data2_in;
    logic          zero_in;
    logic [3:0]    Funct_in;
    logic [4:0]    rd_in;
    logic          Branch_in, prediction_in, MemRead_in, MemtoReg_in, MemWrite_in, RegWrite_in;
    logic [63:0]   alu_result_out, data2_out;
    logic [4:0]    rd_out;
    logic          MemRead_out, MemtoReg_out, MemWrite_out, RegWrite_out;
    logic          flush;
    logic [63:0]   redirect_PC;
    logic          update_valid;
    logic [63:0]   update_PC;
    logic          update_taken;
    logic [CW-1:0] branch_count, mispredict_count;

    ex_mem_branch_stage #(.COUNT_W(CW)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .PC_in(PC_in), .immData_in(immData_in), .alu_result_in(alu_result_in), .data2_in(data2_in),
        .zero_in(zero_in), .Funct_in(Funct_in), .rd_in(rd_in),
        .Branch_in(Branch_in), .prediction_in(prediction_in), .MemRead_in(MemRead_in),
        .MemtoReg_in(MemtoReg_in), .MemWrite_in(MemWrite_in), .RegWrite_in(RegWrite_in),
        .alu_result_out(alu_result_out), .data2_out(data2_out), .rd_out(rd_out),
        .MemRead_out(MemRead_out), .MemtoReg_out(MemtoReg_out), .MemWrite_out(MemWrite_out),
        .RegWrite_out(RegWrite_out), .flush(flush), .redirect_PC(redirect_PC),
        .update_valid(update_valid), .update_PC(update_PC), .update_taken(update_taken),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    // Reference model: expected register contents after the next edge.
    logic [63:0] m_alu, m_data2, m_redir, m_upc;
    logic [4:0]  m_rd;
    logic        m_mr, m_m2r, m_mw, m_rw, m_flush, m_uv, m_ut, m_wrong_path;
    int unsigned m_bc, m_mc;

    task automatic model_reset();
        m_alu = '0; m_data2 = '0; m_redir = '0; m_upc = '0; m_rd = '0;
        m_mr = 0; m_m2r = 0; m_mw = 0; m_rw = 0; m_flush = 0; m_uv = 0; m_ut = 0;
        m_wrong_path = 0; m_bc = 0; m_mc = 0;
    endtask

    function automatic logic ref_taken();
        case (int'(Funct_in) % 8)
            0:       return zero_in;
            1:       return !zero_in;
            4:       return $signed(alu_result_in) < 0;
            5:       return $signed(alu_result_in) >= 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step();
        logic t;
        m_flush = 0;
        m_uv    = 0;
        if (m_wrong_path) begin
            m_wrong_path = 0;
            m_alu = alu_result_in; m_data2 = data2_in;
            m_rd = 0; m_mr = 0; m_m2r = 0; m_mw = 0; m_rw = 0;
        end else if (!stall) begin
            m_alu = alu_result_in; m_data2 = data2_in; m_rd = rd_in;
            m_mr = MemRead_in; m_m2r = MemtoReg_in; m_mw = MemWrite_in; m_rw = RegWrite_in;
            if (Branch_in) begin
                t = ref_taken();
                m_uv = 1; m_upc = PC_in; m_ut = t;
                if (m_bc < CMAX) m_bc++;
                if (t != prediction_in) begin
                    if (m_mc < CMAX) m_mc++;
                    m_flush = 1;
                    m_redir = t ? PC_in + 2 * immData_in : PC_in + 4;
                    m_wrong_path = 1;
                end
            end
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".alu"},    alu_result_out, m_alu);
        chk({tag, ".data2"},  data2_out, m_data2);
        chk({tag, ".rd"},     64'(rd_out), 64'(m_rd));
        chk({tag, ".mr"},     64'(MemRead_out), 64'(m_mr));
        chk({tag, ".m2r"},    64'(MemtoReg_out), 64'(m_m2r));
        chk({tag, ".mw"},     64'(MemWrite_out), 64'(m_mw));
        chk({tag, ".rw"},     64'(RegWrite_out), 64'(m_rw));
        chk({tag, ".flush"},  64'(flush), 64'(m_flush));
        chk({tag, ".redir"},  redirect_PC, m_redir);
        chk({tag, ".uv"},     64'(update_valid), 64'(m_uv));
        chk({tag, ".upc"},    update_PC, m_upc);
        chk({tag, ".ut"},     64'(update_taken), 64'(m_ut));
        chk({tag, ".bc"},     64'(branch_count), 64'(m_bc));
        chk({tag, ".mc"},     64'(mispredict_count), 64'(m_mc));
    endtask

    task automatic clear_inputs();
        stall = 0; PC_in = '0; immData_in = '0; alu_result_in = '0; data2_in = '0;
        zero_in = 0; Funct_in = '0; rd_in = '0; Branch_in = 0; prediction_in = 0;
        MemRead_in = 0; MemtoReg_in = 0; MemWrite_in = 0; RegWrite_in = 0;
    endtask

    task automatic set_branch(input logic [63:0] pc, input logic [63:0] imm, input logic [3:0] f,
                              input logic z, input logic pred);
        clear_inputs();
        Branch_in = 1; PC_in = pc; immData_in = imm; Funct_in = f; zero_in = z; prediction_in = pred;
    endtask

    task automatic pulse_reset();
        reset = 0;
        #2;
        reset = 1;
        model_reset();
    endtask

    typedef struct {
        logic        br, pred, zero;
        logic [3:0]  f;
        logic [63:0] pc, imm, alu;
        logic        mw, rw;
        logic [4:0]  rd;
        logic        e_flush;
        logic [63:0] e_redir;
        logic        e_uv, e_ut;
        logic [3:0]  e_bc, e_mc;
        logic        e_mw;
        logic [4:0]  e_rd;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1,0,1,4'd0, 64'h100, 64'h10, 64'h0, 0,0,5'd0,  1,64'h120,1,1,4'd1,4'd1,0,5'd0};
        tbl[1] = '{0,0,0,4'd0, 64'h104, 64'h0,  64'h0, 0,0,5'd0,  0,64'h120,0,0,4'd1,4'd1,0,5'd0};
        tbl[2] = '{1,1,1,4'd0, 64'h100, 64'h10, 64'h0, 0,0,5'd0,  0,64'h120,1,1,4'd2,4'd1,0,5'd0};
        tbl[3] = '{1,0,1,4'd1, 64'h108, 64'h20, 64'h0, 0,0,5'd0,  0,64'h120,1,0,4'd3,4'd1,0,5'd0};
        tbl[4] = '{1,0,0,4'd4, 64'h200, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8000_0000_0000_0000, 0,0,5'd0,
                   1,64'h1F8,1,1,4'd4,4'd2,0,5'd0};
        tbl[5] = '{1,1,0,4'd0, 64'h204, 64'h40, 64'h0, 1,0,5'd7,  0,64'h1F8,0,0,4'd4,4'd2,0,5'd0};
        tbl[6] = '{1,1,0,4'd5, 64'h300, 64'h10, 64'h8000_0000_0000_0000, 0,0,5'd0,
                   1,64'h304,1,0,4'd5,4'd3,0,5'd0};
        tbl[7] = '{0,0,0,4'd0, 64'h304, 64'h0,  64'h0, 0,1,5'd5,  0,64'h304,0,0,4'd5,4'd3,0,5'd0};
        tbl[8] = '{0,0,0,4'd0, 64'h308, 64'h0,  64'h0, 1,0,5'd9,  0,64'h304,0,0,4'd5,4'd3,1,5'd9};
        tbl[9] = '{1,0,1,4'd3, 64'h30C, 64'h10, 64'h0, 0,0,5'd0,  0,64'h304,1,0,4'd6,4'd3,0,5'd0};

        // Reset state, before and across a clock edge
        clear_inputs();
        reset = 0;
        model_reset();
        #3;
        check_model("reset_async");
        @(posedge clk);
        #1;
        check_model("reset_held");
        reset = 1;

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            clear_inputs();
            Branch_in = tbl[i].br; prediction_in = tbl[i].pred; zero_in = tbl[i].zero;
            Funct_in = tbl[i].f; PC_in = tbl[i].pc; immData_in = tbl[i].imm;
            alu_result_in = tbl[i].alu; MemWrite_in = tbl[i].mw; RegWrite_in = tbl[i].rw;
            rd_in = tbl[i].rd;
            step();
            chk($sformatf("vec%0d.flush", i), 64'(flush), 64'(tbl[i].e_flush));
            chk($sformatf("vec%0d.redir", i), redirect_PC, tbl[i].e_redir);
            chk($sformatf("vec%0d.uv", i), 64'(update_valid), 64'(tbl[i].e_uv));
            if (tbl[i].e_uv) begin
                chk($sformatf("vec%0d.ut", i), 64'(update_taken), 64'(tbl[i].e_ut));
                chk($sformatf("vec%0d.upc", i), update_PC, tbl[i].pc);
            end
            chk($sformatf("vec%0d.bc", i), 64'(branch_count), 64'(tbl[i].e_bc));
            chk($sformatf("vec%0d.mc", i), 64'(mispredict_count), 64'(tbl[i].e_mc));
            chk($sformatf("vec%0d.mw", i), 64'(MemWrite_out), 64'(tbl[i].e_mw));
            chk($sformatf("vec%0d.rd", i), 64'(rd_out), 64'(tbl[i].e_rd));
        end

        // Stall holds a mispredicting branch; flush fires one cycle after release
        set_branch(64'h400, 64'h8, 4'd0, 1, 0);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall.flush", 64'(flush), 64'd0);
            chk("stall.uv", 64'(update_valid), 64'd0);
            chk("stall.bc", 64'(branch_count), 64'd6);
            chk("stall.mc", 64'(mispredict_count), 64'd3);
        end
        stall = 0;
        step();
        chk("stall_rel.flush", 64'(flush), 64'd1);
        chk("stall_rel.redir", redirect_PC, 64'h410);
        chk("stall_rel.bc", 64'(branch_count), 64'd7);
        chk("stall_rel.mc", 64'(mispredict_count), 64'd4);
        clear_inputs();
        step();
        chk("stall_after.flush", 64'(flush), 64'd0);
        check_model("stall_after");

        // Reset asserted during the FLUSH cycle
        set_branch(64'h500, 64'h4, 4'd1, 0, 0);
        step();
        chk("rstflush.flush", 64'(flush), 64'd1);
        chk("rstflush.redir", redirect_PC, 64'h508);
        #2;
        reset = 0;
        model_reset();
        #1;
        check_model("rstflush_async");
        @(posedge clk);
        #1;
        check_model("rstflush_held");
        reset = 1;
        clear_inputs();
        RegWrite_in = 1; rd_in = 5'd3; alu_result_in = 64'hABCD;
        step();
        chk("rstrel.flush", 64'(flush), 64'd0);
        chk("rstrel.redir", redirect_PC, 64'd0);
        chk("rstrel.rd", 64'(rd_out), 64'd3);
        check_model("rstrel");

        // Counter saturation
        pulse_reset();
        for (int i = 0; i < 17; i++) begin
            set_branch(64'h600 + 64'(i * 4), 64'h10, 4'd0, 1, 1);
            step();
            check_model("sat_bc");
        end
        chk("sat.bc", 64'(branch_count), 64'hF);
        chk("sat.mc0", 64'(mispredict_count), 64'd0);
        for (int i = 0; i < 17; i++) begin
            set_branch(64'h700, 64'h10, 4'd0, 1, 0);
            step();
            clear_inputs();
            step();
        end
        chk("sat.mc", 64'(mispredict_count), 64'hF);
        chk("sat.bc2", 64'(branch_count), 64'hF);

        // Random stimulus against the model
        pulse_reset();
        for (int i = 0; i < 400; i++) begin
            stall         = ($urandom_range(0, 3) == 0);
            Branch_in     = $urandom_range(0, 1);
            prediction_in = $urandom_range(0, 1);
            zero_in       = $urandom_range(0, 1);
            Funct_in      = 4'($urandom_range(0, 15));
            PC_in         = {32'($urandom), 32'($urandom)};
            immData_in    = 64'(signed'(32'($urandom)));
            alu_result_in = {32'($urandom), 32'($urandom)};
            data2_in      = {32'($urandom), 32'($urandom)};
            rd_in         = 5'($urandom_range(0, 31));
            MemRead_in    = $urandom_range(0, 1);
            MemtoReg_in   = $urandom_range(0, 1);
            MemWrite_in   = $urandom_range(0, 1);
            RegWrite_in   = $urandom_range(0, 1);
            step();
            check_model("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_mem_branch_stage.md
EX_MEM_BRANCH_STAGE -- requirements
Module: ex_mem_branch_stage

Interface
REQ-001 Parameter: COUNT_W, default 32, width of the branch and mispredict counters.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  asynchronous, active-low reset; clears all state while low.
REQ-004 stall  in  1  hold request from the hazard unit; high freezes the stage.
REQ-005 PC_in, immData_in, alu_result_in, data2_in  in  64 each  operands from ID/EX register and ALU.
REQ-006 zero_in  in  1  ALU zero flag; Funct_in  in  4  branch/function code; rd_in  in  5  destination register.
REQ-007 Branch_in, prediction_in, MemRead_in, MemtoReg_in, MemWrite_in, RegWrite_in  in  1 each  control bits from ID/EX.
REQ-008 alu_result_out, data2_out  out  64 each; rd_out  out  5; MemRead_out, MemtoReg_out, MemWrite_out, RegWrite_out  out  1 each  EX/MEM register.
REQ-009 flush  out  1  one-cycle squash to IF/ID and ID/EX; redirect_PC  out  64  correct fetch address.
REQ-010 update_valid  out  1; update_PC  out  64; update_taken  out  1  predictor training port.
REQ-011 branch_count, mispredict_count  out  COUNT_W each  performance counters.

Function
REQ-012 An EX instruction is "resolving" when state=RUN, stall=0, Branch_in=1.
REQ-013 taken decode from Funct_in[2:0]: 000 -> zero_in; 001 -> !zero_in; 100 -> alu_result_in[63]; 101 -> !alu_result_in[63]; other codes -> 0.
REQ-014 Target = PC_in + (immData_in << 1); fall-through = PC_in + 4; both computed modulo 2^64.
REQ-015 mispredict = resolving AND (taken != prediction_in).
REQ-016 FSM states RUN and FLUSH; RUN -> FLUSH on a mispredict; FLUSH -> RUN unconditionally after one cycle; stall does not hold FLUSH.
REQ-017 On the clock edge that ends a mispredicting cycle, flush is set to 1 and redirect_PC to target if taken, else fall-through; flush is 1 for exactly the one FLUSH cycle.
REQ-018 redirect_PC holds its last value when flush=0.
REQ-019 On any resolving cycle, the next-edge outputs are update_valid=1, update_PC=PC_in, and update_taken=taken; update_valid is 0 in all other cycles.
REQ-020 Latency: EX/MEM outputs, flush, redirect and update appear one cycle after the EX-stage inputs.
REQ-021 RUN with stall=0: EX/MEM fields capture their inputs.
REQ-022 RUN with stall=1: all registers, counters and the state hold.
REQ-023 In FLUSH, the EX instruction is wrong-path and is squashed.
REQ-024 A squash clears MemRead_out, MemtoReg_out, MemWrite_out, RegWrite_out and rd_out to 0, and performs no resolution, no counting and no update.
REQ-025 In FLUSH, a Branch_in=1 is ignored, so back-to-back mispredicts across a FLUSH cycle are impossible.
REQ-026 branch_count increments on every resolving cycle.
REQ-027 mispredict_count increments on every mispredict.
REQ-028 Both counters saturate at all-ones and do not wrap.
REQ-029 A branch in EX writes its own EX/MEM fields normally; branches carry RegWrite=0 and MemWrite=0 from decode.

Reset
REQ-030 While reset=0: state=RUN; every output is 0, including redirect_PC, update_PC and both counters.
REQ-031 Reset asserted mid-FLUSH aborts the FLUSH: flush drops to 0 immediately and no redirect is issued after release.
REQ-032 The first posedge after reset rises performs normal RUN behaviour.

Verification
REQ-033 Stimulus: PC_in=0x100, imm=0x10, Funct=000, zero=1, prediction=0, Branch=1. Response: next cycle flush=1, redirect_PC=0x120, update_taken=1, mispredict_count=1; the cycle after, flush=0.
REQ-034 Stimulus: the same branch with prediction=1. Response: flush stays 0, update_valid=1, branch_count increments, mispredict_count unchanged.
REQ-035 Stimulus: a mispredict followed by a wrong-path store (MemWrite_in=1, Branch_in=1) in the FLUSH cycle. Response: MemWrite_out=0, rd_out=0, counters unchanged, state back to RUN.
REQ-036 Stimulus: stall=1 for 3 cycles with a mispredicting branch in EX. Response: no flush and no counting during the stall; the flush fires one cycle after stall falls.
REQ-037 Stimulus: preload via 2^COUNT_W-1 resolving branches (COUNT_W=4 build). Response: branch_count sticks at 0xF.
REQ-038 Stimulus: reset pulled low during the FLUSH cycle. Response: flush drops asynchronously, all outputs are 0, and there is no redirect after release.
